proj_multi_hasher: RTL and testbench

Pipelined, multi-seed successor to the single-seed k-mer hasher. It accepts one packed k-mer word per handshake and produces NUM_HASHES MurmurHash3-style signatures, LANES at a time over NUM_HASHES/LANES output beats. Seeds live in an internal writable seed table. It sits between the k-mer extractor and the sorter/min-signature stage of the MinHash datapath, and supplies the full signature set per k-mer with valid/ready backpressure.

---
 rtl/proj_multi_hasher.sv | 211 +++++++++++++++++++++
 tb/tb_proj_multi_hasher.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proj_multi_hasher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : proj_multi_hasher
//  Description : Pipelined multi-seed MurmurHash3-style k-mer hasher. Each
//                accepted k-mer is hashed against NUM_HASHES seeds taken from
//                an internal writable seed table. The results leave LANES at a
//                time over NUM_HASHES/LANES beats, under valid/ready flow
//                control.
//  Ports       : clk, rst_n (async, active-low)
//                in_valid/in_ready/in_kmer         - k-mer input handshake
//                seed_we/seed_addr/seed_wdata      - seed table write port
//                out_valid/out_ready/out_sig       - signature beat output
//                out_idx/out_last                  - beat number / final beat
//  Revision    : 1.0 - initial release
// ============================================================================
module proj_multi_hasher #(
    parameter int DATA_BITS  = 32,
    parameter int NUM_HASHES = 8,
    parameter int LANES      = 4,
    localparam int PASSES    = NUM_HASHES / LANES,
    localparam int IDX_W     = (PASSES > 1) ? $clog2(PASSES) : 1,
    localparam int SA_W      = (NUM_HASHES > 1) ? $clog2(NUM_HASHES) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_BITS-1:0]       in_kmer,
    input  logic                       seed_we,
    input  logic [SA_W-1:0]            seed_addr,
    input  logic [DATA_BITS-1:0]       seed_wdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*DATA_BITS-1:0] out_sig,
    output logic [IDX_W-1:0]           out_idx,
    output logic                       out_last
);

    // Parameter legality
    if (DATA_BITS != 32) begin : g_bad_data_bits
        $error("proj_multi_hasher: DATA_BITS must be 32");
    end
    if ((NUM_HASHES % LANES) != 0) begin : g_bad_lanes
        $error("proj_multi_hasher: NUM_HASHES must be a multiple of LANES");
    end

    localparam logic [DATA_BITS-1:0] c_C1        = DATA_BITS'(32'hcc9e2d51);
    localparam logic [DATA_BITS-1:0] c_C2        = DATA_BITS'(32'h1b873593);
    localparam logic [DATA_BITS-1:0] c_N         = DATA_BITS'(32'he6546b64);
    localparam logic [DATA_BITS-1:0] c_FIVE      = DATA_BITS'(5);
    localparam logic [IDX_W-1:0]     c_LAST_PASS = IDX_W'(PASSES - 1);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_ISSUE = 1'b1;

    function automatic logic [DATA_BITS-1:0] rol15(input logic [DATA_BITS-1:0] x);
        return {x[DATA_BITS-16:0], x[DATA_BITS-1:DATA_BITS-15]};
    endfunction

    function automatic logic [DATA_BITS-1:0] rol13(input logic [DATA_BITS-1:0] x);
        return {x[DATA_BITS-14:0], x[DATA_BITS-1:DATA_BITS-13]};
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [IDX_W-1:0]     r_pass;
    logic [DATA_BITS-1:0] r_kmer;
    logic [DATA_BITS-1:0] r_seed [NUM_HASHES];

    logic                 r_v1;
    logic [DATA_BITS-1:0] r_s1_k;
    logic [DATA_BITS-1:0] r_s1_seed [LANES];
    logic [IDX_W-1:0]     r_s1_idx;
    logic                 r_s1_last;

    logic                 r_v2;
    logic [DATA_BITS-1:0] r_s2_h [LANES];
    logic [IDX_W-1:0]     r_s2_idx;
    logic                 r_s2_last;

    logic                       r_out_valid;
    logic [LANES*DATA_BITS-1:0] r_out_sig;
    logic [IDX_W-1:0]           r_out_idx;
    logic                       r_out_last;

    logic                       w_adv;
    logic                       w_issue;
    logic [DATA_BITS-1:0]       w_k2;
    logic [SA_W-1:0]            w_sidx [LANES];
    logic [DATA_BITS-1:0]       w_h    [LANES];
    logic [LANES*DATA_BITS-1:0] w_sig;

    // A single stall signal freezes the whole pipeline, so the output beat
    // and everything behind it hold together while downstream is busy.
    assign w_adv    = !r_out_valid || out_ready;
    assign w_issue  = (r_state == c_ISSUE) && w_adv;
    assign in_ready = (r_state == c_IDLE);

    // The key-mixing half does not depend on the seed, so it is shared.
    assign w_k2 = rol15(r_s1_k) * c_C2;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_sidx[l] = SA_W'(int'(r_pass) * LANES + l);
        assign w_h[l]    = r_s1_seed[l] ^ w_k2;
        assign w_sig[l*DATA_BITS +: DATA_BITS] = rol13(r_s2_h[l]) * c_FIVE + c_N;
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = c_ISSUE;
                end
            end
            c_ISSUE: begin
                if (w_adv && (r_pass == c_LAST_PASS)) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kmer <= '0;
            r_pass <= '0;
        end else if ((r_state == c_IDLE) && in_valid) begin
            r_kmer <= in_kmer;
            r_pass <= '0;
        end else if (w_issue) begin
            r_pass <= (r_pass == c_LAST_PASS) ? '0 : r_pass + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Seed table. Writes are independent of the FSM; an issue on the same
    // edge as a write samples the pre-write value.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_HASHES; i++) begin
                r_seed[i] <= DATA_BITS'(i);
            end
        end else if (seed_we && (int'(seed_addr) < NUM_HASHES)) begin
            r_seed[seed_addr] <= seed_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Three-stage hash pipeline
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1        <= 1'b0;
            r_s1_k      <= '0;
            r_s1_idx    <= '0;
            r_s1_last   <= 1'b0;
            r_v2        <= 1'b0;
            r_s2_idx    <= '0;
            r_s2_last   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sig   <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                r_s1_seed[l] <= '0;
                r_s2_h[l]    <= '0;
            end
        end else if (w_adv) begin
            r_v1      <= w_issue;
            r_s1_k    <= r_kmer * c_C1;
            r_s1_idx  <= r_pass;
            r_s1_last <= (r_pass == c_LAST_PASS);
            for (int l = 0; l < LANES; l++) begin
                r_s1_seed[l] <= r_seed[w_sidx[l]];
                r_s2_h[l]    <= w_h[l];
            end
            r_v2        <= r_v1;
            r_s2_idx    <= r_s1_idx;
            r_s2_last   <= r_s1_last;
            r_out_valid <= r_v2;
            r_out_sig   <= w_sig;
            r_out_idx   <= r_s2_idx;
            r_out_last  <= r_s2_last;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sig   = r_out_sig;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_proj_multi_hasher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_proj_multi_hasher
//  Description : Self-checking bench for proj_multi_hasher. A behavioural
//                MurmurHash3 model plus a seed-table mirror produce the
//                expected beat stream for every accepted k-mer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_proj_multi_hasher;

    localparam int NUM_HASHES = 8;
    localparam int LANES      = 4;
    localparam int PASSES     = NUM_HASHES / LANES;
    localparam int IDX_W      = 1;
    localparam int SA_W       = 3;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_kmer;
    logic                 seed_we;
    logic [SA_W-1:0]      seed_addr;
    logic [31:0]          seed_wdata;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*32-1:0]  out_sig;
    logic [IDX_W-1:0]     out_idx;
    logic                 out_last;

    proj_multi_hasher #(
        .DATA_BITS (32),
        .NUM_HASHES(NUM_HASHES),
        .LANES     (LANES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kmer   (in_kmer),
        .seed_we   (seed_we),
        .seed_addr (seed_addr),
        .seed_wdata(seed_wdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sig   (out_sig),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [LANES*32-1:0] sig;
        logic [IDX_W-1:0]    idx;
        logic                last;
    } beat_t;

    beat_t       q_exp[$];
    beat_t       m_e;
    logic [31:0] m_seed [NUM_HASHES];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          beats_seen = 0;
    int          rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] murmur(input logic [31:0] key, input logic [31:0] seed);
        logic [31:0] k;
        logic [31:0] h;
        k = key * 32'hcc9e2d51;
        k = (k << 15) | (k >> 17);
        k = k * 32'h1b873593;
        h = seed ^ k;
        h = (h << 13) | (h >> 19);
        return h * 32'd5 + 32'he6546b64;
    endfunction

    task automatic push_exp(input logic [31:0] k);
        beat_t e;
        for (int p = 0; p < PASSES; p++) begin
            for (int l = 0; l < LANES; l++) begin
                e.sig[l*32 +: 32] = murmur(k, m_seed[p*LANES + l]);
            end
            e.idx  = IDX_W'(p);
            e.last = (p == PASSES - 1);
            q_exp.push_back(e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_HASHES; i++) m_seed[i] = 32'(i);
    endtask

    // Presents k and returns on the negedge before the accepting edge.
    task automatic send(input logic [31:0] k);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_kmer  = k;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 128'(in_ready), 128'd1);
            in_valid = 1'b0;
        end else begin
            push_exp(k);
        end
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wr_seed(input logic [SA_W-1:0] a, input logic [31:0] d);
        @(negedge clk);
        seed_we    = 1'b1;
        seed_addr  = a;
        seed_wdata = d;
        @(negedge clk);
        seed_we = 1'b0;
        m_seed[a] = d;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q_exp.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (q_exp.size() != 0) chk("drain_timeout", 128'(q_exp.size()), 128'd0);
    endtask

    task automatic wait_out_valid();
        int t;
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) chk("out_valid_timeout", 128'(out_valid), 128'd1);
    endtask

    // out_ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard: every accepted beat must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q_exp.size() == 0) begin
                chk("unexpected_beat", 128'd1, 128'd0);
            end else begin
                m_e = q_exp.pop_front();
                chk("beat_sig", out_sig, m_e.sig);
                chk("beat_idx_last", 128'({out_idx, out_last}), 128'({m_e.idx, m_e.last}));
                beats_seen++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LANES*32-1:0] snap_sig;
        logic [31:0]         k;
        logic [31:0]         s_new;
        int                  b0;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_kmer    = '0;
        seed_we    = 1'b0;
        seed_addr  = '0;
        seed_wdata = '0;
        model_reset();

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_sig", out_sig, 128'd0);
        chk("rst_out_idx_last", 128'({out_idx, out_last}), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        rst_n = 1'b1;

        // ---------------- directed kmer=0, default seeds ----------------
        @(negedge clk);
        in_valid = 1'b1;
        in_kmer  = 32'h0;
        chk("d0_in_ready", 128'(in_ready), 128'd1);
        push_exp(32'h0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("d0_in_ready_low", 128'(in_ready), 128'd0);
        @(negedge clk);                       // between E0 and E1
        @(negedge clk);                       // between E1 and E2
        chk("d0_no_early_valid1", 128'(out_valid), 128'd0);
        @(negedge clk);                       // between E2 and E3
        chk("d0_no_early_valid2", 128'(out_valid), 128'd0);
        chk("d0_in_ready_back", 128'(in_ready), 128'd1);
        @(negedge clk);                       // after E3
        chk("d0_beat0_valid", 128'(out_valid), 128'd1);
        chk("d0_beat0_sig", out_sig,
            {32'he6564b64, 32'he655ab64, 32'he6550b64, 32'he6546b64});
        chk("d0_beat0_idx_last", 128'({out_idx, out_last}), 128'b00);
        @(negedge clk);
        chk("d0_beat1_valid", 128'(out_valid), 128'd1);
        chk("d0_beat1_idx_last", 128'({out_idx, out_last}), 128'b11);
        drain();

        // ---------------- all-zero seeds ----------------
        for (int i = 0; i < NUM_HASHES; i++) wr_seed(SA_W'(i), 32'h0);
        send(32'h0);
        idle_in();
        drain();

        // ---------------- random kmers / seeds ----------------
        rdy_mode = 1;
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                wr_seed(SA_W'($urandom_range(0, NUM_HASHES - 1)), $urandom());
                wr_seed(SA_W'($urandom_range(0, NUM_HASHES - 1)), $urandom());
            end
            send($urandom());
            idle_in();
            drain();
        end

        // ---------------- stall on beat 0 ----------------
        rdy_mode = 0;
        @(negedge clk);
        send($urandom());
        idle_in();
        rdy_mode = 2;
        wait_out_valid();
        chk("stall_beat0_idx", 128'({out_idx, out_last}), 128'b00);
        snap_sig = out_sig;
        send($urandom());                     // accepted, but cannot issue while stalled
        idle_in();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_sig_stable", out_sig, snap_sig);
            chk("stall_idx_stable", 128'({out_idx, out_last}), 128'b00);
            chk("stall_in_ready_low", 128'(in_ready), 128'd0);
        end
        rdy_mode = 0;
        @(negedge clk);
        chk("release_beat0", 128'({out_valid, out_idx, out_last}), 128'b100);
        @(negedge clk);
        chk("release_beat1", 128'({out_valid, out_idx, out_last}), 128'b111);
        drain();

        // ---------------- back-to-back random kmers ----------------
        rdy_mode = 1;
        b0 = beats_seen;
        for (int i = 0; i < 16; i++) send($urandom());
        idle_in();
        drain();
        chk("b2b_beat_count", 128'(beats_seen - b0), 128'(16 * PASSES));

        // ---------------- seed write on pass-0 issue edge ----------------
        rdy_mode = 0;
        k     = $urandom();
        s_new = $urandom();
        @(negedge clk);
        in_valid = 1'b1;
        in_kmer  = k;
        chk("se_in_ready", 128'(in_ready), 128'd1);
        push_exp(k);                          // pass 0 must see the old seed
        @(posedge clk);                       // E0: accept
        #1;
        in_valid   = 1'b0;
        seed_we    = 1'b1;
        seed_addr  = '0;
        seed_wdata = s_new;
        @(posedge clk);                       // E1: pass 0 issue + seed write
        #1;
        seed_we   = 1'b0;
        m_seed[0] = s_new;
        drain();
        send(k);                              // same kmer, now with the new seed
        idle_in();
        drain();

        // ---------------- reset mid-kmer with stalled beat ----------------
        wr_seed(SA_W'(3), $urandom());
        send($urandom());
        idle_in();
        rdy_mode = 2;
        wait_out_valid();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_out_sig", out_sig, 128'd0);
        chk("midrst_in_ready", 128'(in_ready), 128'd1);
        q_exp.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        rdy_mode = 1;
        send($urandom());
        idle_in();
        drain();
        repeat (3) @(negedge clk);
        chk("final_queue_empty", 128'(q_exp.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
